// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master.
// Widths and state encoding used by the top, its interface and bench.
package wb_host_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 16;

  typedef enum logic [1:0] {
     IDLE = 2'd0,
     BUS  = 2'd1,
     RESP = 2'd2
  } wbh_state_e;

endpackage

// File: rtl/wb_host_master_if.sv
// Request/response streams plus the Wishbone master bus.
// master: the host-master side; slave: requester + bus slave side.
interface wb_host_master_if;
   import wb_host_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [WB_AW-1:0] req_adr;
   logic [WB_DW-1:0] req_dat;
   logic [WB_SW-1:0] req_sel;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WB_DW-1:0] rsp_dat;
   logic             rsp_err;

   logic             wbm_cyc_o;
   logic             wbm_stb_o;
   logic             wbm_we_o;
   logic [WB_SW-1:0] wbm_sel_o;
   logic [WB_AW-1:0] wbm_adr_o;
   logic [WB_DW-1:0] wbm_dat_o;
   logic             wbm_ack_i;
   logic [WB_DW-1:0] wbm_dat_i;

   modport master (
      input  req_valid, req_we, req_adr,
      input  req_dat, req_sel,
      output req_ready,
      output rsp_valid, rsp_dat, rsp_err,
      input  rsp_ready,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o,
      output wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      output req_valid, req_we, req_adr,
      output req_dat, req_sel,
      input  req_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      output rsp_ready,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
      input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear
// and flags the final cycle before the transfer must be abandoned.
module wb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TO_W-1:0] LAST =
      TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Single-transfer Wishbone classic master fed by a request stream,
// answering on a response stream; a watchdog aborts stalled cycles.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int TO_W           = TO_W_DEF
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   wb_host_master_if.master bus,
   output logic [7:0] err_count
);

   wbh_state_e state;
   wbh_state_e next;

   logic             ready_q;
   logic             we_q;
   logic [WB_AW-1:0] adr_q;
   logic [WB_DW-1:0] dat_q;
   logic [WB_SW-1:0] sel_q;
   logic [WB_DW-1:0] rdat_q;
   logic             rerr_q;
   logic [7:0]       errs_q;

   logic in_bus;
   logic accept;
   logic ack;
   logic expired;
   logic tmo;

   assign in_bus = (state == BUS);
   assign accept = (state == IDLE) && ready_q
                   && bus.req_valid;
   assign ack    = in_bus && bus.wbm_ack_i;
   // Ack in the watchdog's last cycle still completes normally.
   assign tmo    = expired && !bus.wbm_ack_i;

   wb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_tmo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (accept),
      .enable  (in_bus),
      .expired (expired)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               next = BUS;
            end
         end
         BUS: begin
            if (ack || tmo) begin
               next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               next = IDLE;
            end
         end
         default: next = IDLE;
      endcase
   end

   // req_ready is registered so it stays low through reset release.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         rdat_q  <= '0;
         rerr_q  <= 1'b0;
         errs_q  <= '0;
      end else begin
         ready_q <= (next == IDLE);
         if (accept) begin
            we_q  <= bus.req_we;
            adr_q <= bus.req_adr;
            dat_q <= bus.req_dat;
            sel_q <= bus.req_sel;
         end
         if (ack) begin
            rdat_q <= we_q ? '0 : bus.wbm_dat_i;
            rerr_q <= 1'b0;
         end else if (tmo) begin
            rdat_q <= '0;
            rerr_q <= 1'b1;
            if (errs_q != 8'hFF) begin
               errs_q <= errs_q + 8'd1;
            end
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_dat   = rdat_q;
   assign bus.rsp_err   = rerr_q;
   assign bus.wbm_cyc_o = in_bus;
   assign bus.wbm_stb_o = in_bus;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign err_count     = errs_q;

endmodule
